// File: rtl/nf10_axis_pkg.sv
// nf10_axis_pkg: shared constants, types and the round-robin pick helper
// used by the nf10 AXI4-Stream input arbiter.
package nf10_axis_pkg;
    localparam int NUM_PORTS = 5;
    localparam int DATA_W    = 256;
    localparam int STRB_W    = DATA_W / 8;
    localparam int TUSER_W   = 128;
    localparam int STAT_W    = 32;

    typedef enum logic {IDLE, SEND} arb_state_t;
    typedef logic [2:0] port_t;

    // Returns {found, port}: first requester after last, wrapping round to last itself
    function automatic logic [3:0] rr_pick(input port_t last, input logic [NUM_PORTS-1:0] req);
        logic [3:0] r;
        port_t p;
        r = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            p = port_t'((int'(last) + i) % NUM_PORTS);
            if (req[p]) r = {1'b1, p};
        end
        return r;
    endfunction
endpackage

// File: rtl/nf10_axis_small_fifo.sv
// nf10_axis_small_fifo: flop-based FIFO with registered head, count, full and empty.
// A full FIFO refuses writes even when it is read in the same cycle.
module nf10_axis_small_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_wr,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_we, w_re;

    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_we    = i_wr && !o_full;
    assign w_re    = i_rd && !o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_we);
            r_rd_ptr <= r_rd_ptr + AW'(w_re);
            r_count  <= r_count + CW'(w_we) - CW'(w_re);
        end
    end

    always_ff @(posedge i_clk)
        if (w_we) r_mem[r_wr_ptr] <= i_din;
endmodule

// File: rtl/nf10_rr_input_arbiter.sv
// nf10_rr_input_arbiter: five buffered AXI4-Stream inputs merged packet-by-packet in round-robin order.
// Define ARB_PKT_STATS_EN to add stat_pkt_count, five 32-bit per-port packet counters.
module nf10_rr_input_arbiter
    import nf10_axis_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = DATA_W,
    parameter int C_S_AXIS_DATA_WIDTH  = DATA_W,
    parameter int C_M_AXIS_TUSER_WIDTH = TUSER_W,
    parameter int C_S_AXIS_TUSER_WIDTH = TUSER_W,
    parameter int C_FIFO_DEPTH         = 8
) (
    input  logic                                axi_aclk,
    input  logic                                axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_0,
    input  logic                                s_axis_tvalid_0,
    output logic                                s_axis_tready_0,
    input  logic                                s_axis_tlast_0,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_1,
    input  logic                                s_axis_tvalid_1,
    output logic                                s_axis_tready_1,
    input  logic                                s_axis_tlast_1,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_2,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_2,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_2,
    input  logic                                s_axis_tvalid_2,
    output logic                                s_axis_tready_2,
    input  logic                                s_axis_tlast_2,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_3,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_3,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_3,
    input  logic                                s_axis_tvalid_3,
    output logic                                s_axis_tready_3,
    input  logic                                s_axis_tlast_3,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_4,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_4,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_4,
    input  logic                                s_axis_tvalid_4,
    output logic                                s_axis_tready_4,
    input  logic                                s_axis_tlast_4,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
`ifdef ARB_PKT_STATS_EN
    output logic [NUM_PORTS*STAT_W-1:0]         stat_pkt_count,
`endif
    output logic                                m_axis_tlast
);
    localparam int DW = C_M_AXIS_DATA_WIDTH;
    localparam int FW = 1 + C_M_AXIS_TUSER_WIDTH + DW / 8 + DW;
    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FW-1:0]        w_din   [NUM_PORTS];
    logic [FW-1:0]        w_dout  [NUM_PORTS];
    logic [AW:0]          w_count [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_s_valid, w_rdy, w_full, w_empty, w_wr, w_rd, w_req;
    logic [FW-1:0]        w_head;
    logic [3:0]           w_pick;
    logic                 w_m_valid, w_pop, w_eop;
    arb_state_t           r_state, w_state_nxt;
    port_t                r_grant, r_last_grant, w_grant_nxt, w_last_grant_nxt;

    assign w_din[0] = {s_axis_tlast_0, s_axis_tuser_0, s_axis_tstrb_0, s_axis_tdata_0};
    assign w_din[1] = {s_axis_tlast_1, s_axis_tuser_1, s_axis_tstrb_1, s_axis_tdata_1};
    assign w_din[2] = {s_axis_tlast_2, s_axis_tuser_2, s_axis_tstrb_2, s_axis_tdata_2};
    assign w_din[3] = {s_axis_tlast_3, s_axis_tuser_3, s_axis_tstrb_3, s_axis_tdata_3};
    assign w_din[4] = {s_axis_tlast_4, s_axis_tuser_4, s_axis_tstrb_4, s_axis_tdata_4};
    assign w_s_valid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    // Ready is forced low while reset is held so nothing is accepted into a clearing FIFO
    assign w_rdy = ~w_full & {NUM_PORTS{~axi_reset}};
    assign {s_axis_tready_4, s_axis_tready_3, s_axis_tready_2, s_axis_tready_1, s_axis_tready_0} = w_rdy;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        assign w_wr[g] = w_s_valid[g] && w_rdy[g];
        assign w_rd[g] = w_pop && r_grant == port_t'(g);
        nf10_axis_small_fifo #(.WIDTH(FW), .DEPTH(C_FIFO_DEPTH)) u_fifo (
            .i_clk   (axi_aclk),
            .i_rst   (axi_reset),
            .i_din   (w_din[g]),
            .i_wr    (w_wr[g]),
            .i_rd    (w_rd[g]),
            .o_dout  (w_dout[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_count (w_count[g])
        );
    end

    assign w_head    = w_dout[r_grant];
    assign w_m_valid = r_state == SEND && !w_empty[r_grant];
    assign w_pop     = w_m_valid && m_axis_tready;
    assign w_eop     = w_pop && w_head[FW-1];

    // The granted port only competes again if it still holds data after this pop
    always_comb begin
        w_req = ~w_empty;
        if (r_state == SEND) w_req[r_grant] = w_count[r_grant] > CW'(1);
        w_pick = rr_pick(r_state == SEND ? r_grant : r_last_grant, w_req);
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= port_t'(NUM_PORTS - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = w_eop ? r_grant : r_last_grant;
        if (r_state == IDLE || w_eop) begin
            w_state_nxt = w_pick[3] ? SEND : IDLE;
            w_grant_nxt = w_pick[3] ? w_pick[2:0] : r_grant;
        end
    end

    always_comb begin
        m_axis_tvalid = w_m_valid;
        {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = w_m_valid ? w_head : '0;
    end

`ifdef ARB_PKT_STATS_EN
    logic [STAT_W-1:0] r_stat [NUM_PORTS];

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) r_stat <= '{default: '0};
        else if (w_eop) r_stat[r_grant] <= r_stat[r_grant] + STAT_W'(1);
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
        assign stat_pkt_count[g*STAT_W +: STAT_W] = r_stat[g];
    end
`endif
endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
// tb_nf10_rr_input_arbiter: per-cycle vector table plus scoreboarded packet sequences
// for the five-port round-robin input arbiter (optionally with ARB_PKT_STATS_EN).
module tb_nf10_rr_input_arbiter;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic [255:0] s_tdata [5];
    logic [31:0]  s_tstrb [5];
    logic [127:0] s_tuser [5];
    logic [4:0]   s_tvalid, s_tlast, s_tready;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid, m_tlast, m_tready;
`ifdef ARB_PKT_STATS_EN
    logic [159:0] stat;
`endif

    nf10_rr_input_arbiter dut (
        .axi_aclk(clk), .axi_reset(rst),
        .s_axis_tdata_0(s_tdata[0]), .s_axis_tstrb_0(s_tstrb[0]), .s_axis_tuser_0(s_tuser[0]),
        .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tready_0(s_tready[0]), .s_axis_tlast_0(s_tlast[0]),
        .s_axis_tdata_1(s_tdata[1]), .s_axis_tstrb_1(s_tstrb[1]), .s_axis_tuser_1(s_tuser[1]),
        .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tready_1(s_tready[1]), .s_axis_tlast_1(s_tlast[1]),
        .s_axis_tdata_2(s_tdata[2]), .s_axis_tstrb_2(s_tstrb[2]), .s_axis_tuser_2(s_tuser[2]),
        .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tready_2(s_tready[2]), .s_axis_tlast_2(s_tlast[2]),
        .s_axis_tdata_3(s_tdata[3]), .s_axis_tstrb_3(s_tstrb[3]), .s_axis_tuser_3(s_tuser[3]),
        .s_axis_tvalid_3(s_tvalid[3]), .s_axis_tready_3(s_tready[3]), .s_axis_tlast_3(s_tlast[3]),
        .s_axis_tdata_4(s_tdata[4]), .s_axis_tstrb_4(s_tstrb[4]), .s_axis_tuser_4(s_tuser[4]),
        .s_axis_tvalid_4(s_tvalid[4]), .s_axis_tready_4(s_tready[4]), .s_axis_tlast_4(s_tlast[4]),
`ifdef ARB_PKT_STATS_EN
        .stat_pkt_count(stat),
`endif
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
    );

    typedef struct packed {logic [7:0] seq; logic last;} beat_t;
    typedef struct packed {logic [2:0] port; logic [7:0] seq; logic last;} exp_t;
    typedef struct packed {
        logic [4:0] vld; logic [4:0] lst; logic [7:0] seq; logic mrdy;
        logic etv; logic [2:0] eport; logic [7:0] eseq; logic elast; logic [4:0] erdy;
    } vec_t;

    int n_chk = 0, n_fail = 0, cyc = 0, hs_first = -1, hs_last = -1;
    beat_t src_q [5][$];
    exp_t exp_q [$];
    logic [4:0] hold = 0;
    logic rdy_mode = 0, rdy_val = 1, prev_stall = 0, prev_last = 0, mon_tv = 0;
    logic [255:0] prev_data = 0;
    vec_t vecs [12];

    function automatic logic [255:0] word(input int p, input int s);
        return {8'(p), 8'(s), {30{8'(p * 16 + s)}}};
    endfunction
    function automatic logic [31:0] strb(input int p, input int s);
        return {8'(p), 8'(s), 16'hA5C3};
    endfunction
    function automatic logic [127:0] usr(input int p, input int s);
        return {96'(0), 8'(p), 8'(s), 16'hBEEF};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_port(input int p, input logic v, input logic l, input int s);
        s_tvalid[p] = v;
        s_tlast[p]  = l;
        s_tdata[p]  = word(p, s);
        s_tstrb[p]  = strb(p, s);
        s_tuser[p]  = usr(p, s);
    endtask

    task automatic src_pkt(input int p, input int n, input int base);
        for (int i = 0; i < n; i++) src_q[p].push_back({8'(base + i), i == n - 1});
    endtask
    task automatic exp_pkt(input int p, input int n, input int base);
        for (int i = 0; i < n; i++) exp_q.push_back({3'(p), 8'(base + i), i == n - 1});
    endtask

    // One clock: drive sources, check outputs at the falling edge, retire accepted beats
    task automatic tick();
        logic [4:0] rdy;
        exp_t e;
        for (int p = 0; p < 5; p++)
            if (src_q[p].size() > 0 && !hold[p]) drive_port(p, 1'b1, src_q[p][0].last, int'(src_q[p][0].seq));
            else drive_port(p, 1'b0, 1'b0, 0);
        m_tready = rdy_mode ? ~m_tready : rdy_val;
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_tvalid", 256'(m_tvalid), 256'(1));
            chk("stall_tdata", m_tdata, prev_data);
            chk("stall_tlast", 256'(m_tlast), 256'(prev_last));
        end
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL extra_word: got %h, expected no output", m_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("sb_tdata", m_tdata, word(int'(e.port), int'(e.seq)));
                chk("sb_tstrb", 256'(m_tstrb), 256'(strb(int'(e.port), int'(e.seq))));
                chk("sb_tuser", 256'(m_tuser), 256'(usr(int'(e.port), int'(e.seq))));
                chk("sb_tlast", 256'(m_tlast), 256'(e.last));
            end
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
        end
        mon_tv = m_tvalid;
        prev_stall = m_tvalid && !m_tready;
        prev_data = m_tdata;
        prev_last = m_tlast;
        rdy = s_tready;
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < 5; p++)
            if (s_tvalid[p] && rdy[p]) void'(src_q[p].pop_front());
    endtask

    task automatic drain(input int limit);
        int n = 0;
        int busy = 1;
        while (busy != 0 && n < limit) begin
            tick();
            n++;
            busy = exp_q.size();
            for (int p = 0; p < 5; p++) busy += src_q[p].size();
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst = 1;
        hold = 0;
        m_tready = 0;
        for (int p = 0; p < 5; p++) begin
            drive_port(p, 1'b0, 1'b0, 0);
            src_q[p].delete();
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 256'(s_tready), 256'(0));
        chk("rst_m_tvalid", 256'(m_tvalid), 256'(0));
        chk("rst_m_tdata", m_tdata, 256'(0));
        rst = 0;
        @(posedge clk);
        #1;
        prev_stall = 0;
        hs_first = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // vld, lst, seq, mrdy | exp tvalid, port, seq, tlast, s_tready
        vecs[0]  = '{5'b00100, 5'b00000, 8'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'b11111};
        vecs[1]  = '{5'b00100, 5'b00000, 8'd1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'b11111};
        vecs[2]  = '{5'b00100, 5'b00100, 8'd2, 1'b1, 1'b1, 3'd2, 8'd0, 1'b0, 5'b11111};
        vecs[3]  = '{5'b00000, 5'b00000, 8'd0, 1'b1, 1'b1, 3'd2, 8'd1, 1'b0, 5'b11111};
        vecs[4]  = '{5'b00000, 5'b00000, 8'd0, 1'b1, 1'b1, 3'd2, 8'd2, 1'b1, 5'b11111};
        vecs[5]  = '{5'b00000, 5'b00000, 8'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'b11111};
        vecs[6]  = '{5'b00001, 5'b00001, 8'd7, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'b11111};
        vecs[7]  = '{5'b00000, 5'b00000, 8'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'b11111};
        vecs[8]  = '{5'b00000, 5'b00000, 8'd0, 1'b0, 1'b1, 3'd0, 8'd7, 1'b1, 5'b11111};
        vecs[9]  = '{5'b00000, 5'b00000, 8'd0, 1'b0, 1'b1, 3'd0, 8'd7, 1'b1, 5'b11111};
        vecs[10] = '{5'b00000, 5'b00000, 8'd0, 1'b1, 1'b1, 3'd0, 8'd7, 1'b1, 5'b11111};
        vecs[11] = '{5'b00000, 5'b00000, 8'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 5'b11111};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < 5; p++) drive_port(p, vecs[i].vld[p], vecs[i].lst[p], int'(vecs[i].seq));
            m_tready = vecs[i].mrdy;
            @(negedge clk);
            chk($sformatf("vec%0d_tvalid", i), 256'(m_tvalid), 256'(vecs[i].etv));
            chk($sformatf("vec%0d_tdata", i), m_tdata,
                vecs[i].etv ? word(int'(vecs[i].eport), int'(vecs[i].eseq)) : 256'(0));
            chk($sformatf("vec%0d_tlast", i), 256'(m_tlast), 256'(vecs[i].elast));
            chk($sformatf("vec%0d_s_tready", i), 256'(s_tready), 256'(vecs[i].erdy));
            @(posedge clk);
            #1;
        end

        // Simultaneous packets on 0,1,4: back-to-back in port order
        do_reset();
        rdy_val = 1;
        src_pkt(0, 2, 'h10); src_pkt(1, 2, 'h20); src_pkt(4, 2, 'h40);
        exp_pkt(0, 2, 'h10); exp_pkt(1, 2, 'h20); exp_pkt(4, 2, 'h40);
        drain(50);
        chk("no_bubble_span", 256'(hs_last - hs_first + 1), 256'(6));

        // Port 3 fills its FIFO while the output is blocked
        do_reset();
        rdy_val = 0;
        src_pkt(3, 12, 'h30);
        exp_pkt(3, 12, 'h30);
        repeat (12) tick();
        chk("full_accepted", 256'(12 - src_q[3].size()), 256'(8));
        chk("full_tready3", 256'(s_tready[3]), 256'(0));
        rdy_val = 1;
        drain(100);

        // Port 1 stalls mid-packet while port 0 is backlogged
        do_reset();
        rdy_val = 1;
        src_pkt(1, 4, 'h50);
        exp_pkt(1, 4, 'h50); exp_pkt(0, 3, 'h60); exp_pkt(0, 3, 'h70);
        tick();
        src_pkt(0, 3, 'h60); src_pkt(0, 3, 'h70);
        tick();
        hold[1] = 1;
        repeat (3) tick();
        chk("stall_gap_c4", 256'(mon_tv), 256'(0));
        tick();
        chk("stall_gap_c5", 256'(mon_tv), 256'(0));
        hold[1] = 0;
        tick();
        chk("stall_gap_c6", 256'(mon_tv), 256'(0));
        drain(100);

        // All five backlogged: strict 0..4 rotation
        do_reset();
        for (int p = 0; p < 5; p++) begin
            src_pkt(p, 1, 'h80 + p);
            src_pkt(p, 1, 'h88 + p);
        end
        for (int p = 0; p < 5; p++) exp_pkt(p, 1, 'h80 + p);
        for (int p = 0; p < 5; p++) exp_pkt(p, 1, 'h88 + p);
        drain(100);

        // Output ready toggles every cycle
        do_reset();
        rdy_mode = 1;
        src_pkt(2, 5, 'hA0); src_pkt(3, 5, 'hB0);
        exp_pkt(2, 5, 'hA0); exp_pkt(3, 5, 'hB0);
        drain(200);
        rdy_mode = 0;

        // Reset in the middle of a packet
        do_reset();
        rdy_val = 1;
        src_pkt(0, 6, 'hC0);
        exp_pkt(0, 6, 'hC0);
        repeat (4) tick();
        chk("mid_pkt_tvalid_before", 256'(m_tvalid), 256'(1));
        #2;
        rst = 1;
        #1;
        chk("async_rst_tvalid", 256'(m_tvalid), 256'(0));
        chk("async_rst_tdata", m_tdata, 256'(0));
        chk("async_rst_tlast", 256'(m_tlast), 256'(0));
        chk("async_rst_s_tready", 256'(s_tready), 256'(0));
        do_reset();
        src_pkt(0, 2, 'hD0);
        exp_pkt(0, 2, 'hD0);
        drain(50);
`ifdef ARB_PKT_STATS_EN
        chk("stat_port0", 256'(stat[31:0]), 256'(1));
        chk("stat_others", 256'(stat[159:32]), 256'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
